// File: rtl/mem_access_unit_if.sv
// Data-memory port between the load/store unit and memory.
// The unit drives the request; memory drives acceptance and the response.
interface mem_access_unit_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 32
);
    logic                    memory_read;
    logic                    memory_write;
    logic [ADDRESS_BITS-1:0] memory_address;
    logic [3:0]              memory_byte_en;
    logic [DATA_WIDTH-1:0]   memory_data;
    logic                    memory_req_ready;
    logic                    memory_resp_valid;
    logic [DATA_WIDTH-1:0]   memory_resp_data;

    modport master (
        output memory_read,
        output memory_write,
        output memory_address,
        output memory_byte_en,
        output memory_data,
        input  memory_req_ready,
        input  memory_resp_valid,
        input  memory_resp_data
    );

    modport slave (
        input  memory_read,
        input  memory_write,
        input  memory_address,
        input  memory_byte_en,
        input  memory_data,
        output memory_req_ready,
        output memory_resp_valid,
        output memory_resp_data
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store access stage: one registered memory request per instruction,
// aligned and extended load data back to writeback, misaligned-access faults.
module mem_access_unit #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    issue_valid,
    output logic                    issue_ready,
    input  logic [DATA_WIDTH-1:0]   ALU_result,
    input  logic                    load,
    input  logic                    store,
    input  logic [1:0]              log2_bytes,
    input  logic                    unsigned_load,
    input  logic [DATA_WIDTH-1:0]   store_data,
    mem_access_unit_if.master       mem,
    output logic                    load_valid,
    output logic [DATA_WIDTH-1:0]   load_data,
    output logic                    misaligned,
    output logic [ADDRESS_BITS-1:0] fault_address,
    output logic                    stall
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] REQ       = 2'd1;
    localparam logic [1:0] WAIT_RESP = 2'd2;

    logic [1:0] state;
    logic [1:0] lane_q;
    logic [1:0] size_q;
    logic       uns_q;

    logic                  accept;
    logic                  is_mem;
    logic                  bad_align;
    logic [3:0]            byte_en;
    logic [DATA_WIDTH-1:0] wdata;
    logic [7:0]            rbyte;
    logic [15:0]           rhalf;
    logic [DATA_WIDTH-1:0] rdata;

    assign issue_ready = (state == IDLE) && !reset;
    assign stall       = (state != IDLE) && !reset;
    assign accept      = issue_valid && issue_ready;
    assign is_mem      = load || store;

    always_comb begin
        bad_align = 1'b0;
        byte_en   = 4'b1111;
        wdata     = store_data;
        unique case (log2_bytes)
            2'd0: begin
                byte_en = 4'b0001 << ALU_result[1:0];
                wdata   = {4{store_data[7:0]}};
            end
            2'd1: begin
                bad_align = ALU_result[0];
                byte_en   = 4'b0011 << ALU_result[1:0];
                wdata     = {2{store_data[15:0]}};
            end
            2'd2: begin
                bad_align = (ALU_result[1:0] != 2'b00);
            end
            default: begin
                bad_align = 1'b1;
            end
        endcase
    end

    // Lane selection uses the address latched at issue, not the live ALU bus.
    always_comb begin
        rbyte = mem.memory_resp_data[{lane_q, 3'b000} +: 8];
        rhalf = lane_q[1] ? mem.memory_resp_data[31:16]
                          : mem.memory_resp_data[15:0];
        rdata = mem.memory_resp_data;
        unique case (size_q)
            2'd0: rdata = uns_q ? {{(DATA_WIDTH-8){1'b0}}, rbyte}
                                : {{(DATA_WIDTH-8){rbyte[7]}}, rbyte};
            2'd1: rdata = uns_q ? {{(DATA_WIDTH-16){1'b0}}, rhalf}
                                : {{(DATA_WIDTH-16){rhalf[15]}}, rhalf};
            default: rdata = mem.memory_resp_data;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state              <= IDLE;
            lane_q             <= 2'b00;
            size_q             <= 2'b00;
            uns_q              <= 1'b0;
            mem.memory_read    <= 1'b0;
            mem.memory_write   <= 1'b0;
            mem.memory_address <= '0;
            mem.memory_byte_en <= 4'b0000;
            mem.memory_data    <= '0;
            load_valid         <= 1'b0;
            load_data          <= '0;
            misaligned         <= 1'b0;
            fault_address      <= '0;
        end else begin
            load_valid <= 1'b0;
            misaligned <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept && is_mem) begin
                        if (bad_align) begin
                            misaligned    <= 1'b1;
                            fault_address <= ALU_result[ADDRESS_BITS-1:0];
                        end else begin
                            // A load with store also set wins as a load.
                            mem.memory_read    <= load;
                            mem.memory_write   <= !load;
                            mem.memory_address <=
                                {ALU_result[ADDRESS_BITS-1:2], 2'b00};
                            mem.memory_byte_en <= byte_en;
                            mem.memory_data    <= load ? '0 : wdata;
                            lane_q             <= ALU_result[1:0];
                            size_q             <= log2_bytes;
                            uns_q              <= unsigned_load;
                            state              <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (mem.memory_req_ready) begin
                        mem.memory_read  <= 1'b0;
                        mem.memory_write <= 1'b0;
                        state <= mem.memory_read ? WAIT_RESP : IDLE;
                    end
                end
                WAIT_RESP: begin
                    if (mem.memory_resp_valid) begin
                        load_data  <= rdata;
                        load_valid <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a queue-based scoreboard.
// Stimulus pushes expected requests/loads/faults; a monitor pops and compares.
module tb_mem_access_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        issue_valid;
    logic        issue_ready;
    logic [31:0] ALU_result;
    logic        load;
    logic        store;
    logic [1:0]  log2_bytes;
    logic        unsigned_load;
    logic [31:0] store_data;
    logic        load_valid;
    logic [31:0] load_data;
    logic        misaligned;
    logic [31:0] fault_address;
    logic        stall;

    mem_access_unit_if bus ();

    mem_access_unit dut (
        .clock         (clock),
        .reset         (reset),
        .issue_valid   (issue_valid),
        .issue_ready   (issue_ready),
        .ALU_result    (ALU_result),
        .load          (load),
        .store         (store),
        .log2_bytes    (log2_bytes),
        .unsigned_load (unsigned_load),
        .store_data    (store_data),
        .mem           (bus),
        .load_valid    (load_valid),
        .load_data     (load_data),
        .misaligned    (misaligned),
        .fault_address (fault_address),
        .stall         (stall)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } req_t;

    req_t        req_q[$];
    logic [31:0] load_q[$];
    logic [31:0] mis_q[$];
    int          checks = 0;
    int          fails  = 0;

    function automatic req_t mk_req(logic rd, logic wr, logic [31:0] a,
                                    logic [3:0] be, logic [31:0] d);
        req_t r;
        r.rd = rd; r.wr = wr; r.addr = a; r.be = be; r.data = d;
        return r;
    endfunction

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endfunction

    function automatic void chkb(string nm, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b, expected %b", nm, act, exp);
        end
    endfunction

    function automatic void missing(string nm);
        checks++;
        fails++;
        $display("FAIL %s: got unexpected event, expected none queued", nm);
    endfunction

    // Monitor: sample mid-cycle, compare against the scoreboard queues.
    req_t        mon_r;
    logic [31:0] mon_w;
    always @(negedge clock) begin
        if ((bus.memory_read || bus.memory_write) && bus.memory_req_ready) begin
            if (req_q.size() == 0) missing("req_unexpected");
            else begin
                mon_r = req_q.pop_front();
                chkb("req_read", bus.memory_read, mon_r.rd);
                chkb("req_write", bus.memory_write, mon_r.wr);
                chk("req_addr", bus.memory_address, mon_r.addr);
                chk("req_byte_en", {28'b0, bus.memory_byte_en}, {28'b0, mon_r.be});
                if (mon_r.wr) chk("req_data", bus.memory_data, mon_r.data);
            end
        end
        if (load_valid) begin
            if (load_q.size() == 0) missing("load_unexpected");
            else begin
                mon_w = load_q.pop_front();
                chk("load_data", load_data, mon_w);
            end
        end
        if (misaligned) begin
            if (mis_q.size() == 0) missing("fault_unexpected");
            else begin
                mon_w = mis_q.pop_front();
                chk("fault_address", fault_address, mon_w);
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(logic [31:0] a, logic ld, logic st, logic [1:0] sz,
                         logic uns, logic [31:0] sd);
        issue_valid   = 1'b1;
        ALU_result    = a;
        load          = ld;
        store         = st;
        log2_bytes    = sz;
        unsigned_load = uns;
        store_data    = sd;
        chkb("issue_ready", issue_ready, 1'b1);
        cyc();
        issue_valid = 1'b0;
        load        = 1'b0;
        store       = 1'b0;
    endtask

    task automatic do_load(logic [31:0] a, logic st, logic [1:0] sz, logic uns,
                           logic [31:0] resp, logic [3:0] be,
                           logic [31:0] expd, int waits);
        req_q.push_back(mk_req(1'b1, 1'b0, {a[31:2], 2'b00}, be, 32'h0));
        load_q.push_back(expd);
        issue(a, 1'b1, st, sz, uns, 32'h5A5A5A5A);
        chkb("ld_read", bus.memory_read, 1'b1);
        chkb("ld_no_write", bus.memory_write, 1'b0);
        for (int i = 0; i < waits; i++) begin
            bus.memory_resp_valid = 1'b1;
            bus.memory_resp_data  = 32'hBAD0BAD0;
            cyc();
            bus.memory_resp_valid = 1'b0;
            chkb("ld_read_held", bus.memory_read, 1'b1);
            chkb("ld_no_early_valid", load_valid, 1'b0);
        end
        bus.memory_req_ready = 1'b1;
        cyc();
        bus.memory_req_ready = 1'b0;
        chkb("ld_wait_stall", stall, 1'b1);
        chkb("ld_read_dropped", bus.memory_read, 1'b0);
        bus.memory_resp_valid = 1'b1;
        bus.memory_resp_data  = resp;
        cyc();
        bus.memory_resp_valid = 1'b0;
        chkb("ld_valid", load_valid, 1'b1);
        chkb("ld_stall_low", stall, 1'b0);
        cyc();
        chkb("ld_valid_pulse", load_valid, 1'b0);
    endtask

    task automatic do_store(logic [31:0] a, logic [1:0] sz, logic [31:0] sd,
                            logic [3:0] be, logic [31:0] expd);
        req_q.push_back(mk_req(1'b0, 1'b1, {a[31:2], 2'b00}, be, expd));
        issue(a, 1'b0, 1'b1, sz, 1'b0, sd);
        chkb("st_write", bus.memory_write, 1'b1);
        bus.memory_req_ready = 1'b1;
        cyc();
        bus.memory_req_ready = 1'b0;
        chkb("st_write_dropped", bus.memory_write, 1'b0);
        chkb("st_back_idle", issue_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        issue_valid = 0; ALU_result = 0; load = 0; store = 0;
        log2_bytes = 0; unsigned_load = 0; store_data = 0;
        bus.memory_req_ready = 0; bus.memory_resp_valid = 0;
        bus.memory_resp_data = 0;
        cyc(); cyc();

        chkb("rst_issue_ready", issue_ready, 1'b0);
        chkb("rst_stall", stall, 1'b0);
        chkb("rst_read", bus.memory_read, 1'b0);
        chkb("rst_write", bus.memory_write, 1'b0);
        chk("rst_addr", bus.memory_address, 32'h0);
        chk("rst_load_data", load_data, 32'h0);
        chkb("rst_misaligned", misaligned, 1'b0);
        reset = 1'b0;
        cyc();
        chkb("idle_issue_ready", issue_ready, 1'b1);

        // Word store with two wait states: write held three cycles.
        req_q.push_back(mk_req(1'b0, 1'b1, 32'h100, 4'hF, 32'hDEADBEEF));
        issue(32'h100, 1'b0, 1'b1, 2'd2, 1'b0, 32'hDEADBEEF);
        for (int i = 0; i < 3; i++) begin
            chkb("st_write_held", bus.memory_write, 1'b1);
            chk("st_addr_held", bus.memory_address, 32'h100);
            chk("st_data_held", bus.memory_data, 32'hDEADBEEF);
            chkb("st_stall", stall, 1'b1);
            if (i == 2) bus.memory_req_ready = 1'b1;
            cyc();
        end
        bus.memory_req_ready = 1'b0;
        chkb("st_write_dropped", bus.memory_write, 1'b0);
        chkb("st_idle", issue_ready, 1'b1);

        do_load(32'h203, 1'b0, 2'd0, 1'b0, 32'h80FF7F01, 4'b1000, 32'hFFFFFF80, 0);
        do_load(32'h203, 1'b0, 2'd0, 1'b1, 32'h80FF7F01, 4'b1000, 32'h00000080, 0);
        do_load(32'h21,  1'b0, 2'd0, 1'b0, 32'h80017F00, 4'b0010, 32'h0000007F, 1);
        do_load(32'h22,  1'b0, 2'd1, 1'b0, 32'h80017F00, 4'b1100, 32'hFFFF8001, 2);
        do_load(32'h20,  1'b0, 2'd1, 1'b1, 32'h80019F00, 4'b0011, 32'h00009F00, 0);
        do_load(32'h20,  1'b1, 2'd2, 1'b0, 32'h01020304, 4'b1111, 32'h01020304, 0);

        do_store(32'h42, 2'd1, 32'h1234ABCD, 4'b1100, 32'hABCDABCD);
        do_store(32'h07, 2'd0, 32'h000000A5, 4'b1000, 32'hA5A5A5A5);

        // Misaligned word load, then a legal load issued the very next cycle.
        mis_q.push_back(32'h102);
        issue(32'h102, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0);
        chkb("mis_pulse", misaligned, 1'b1);
        chk("mis_fault_addr", fault_address, 32'h102);
        chkb("mis_no_read", bus.memory_read, 1'b0);
        chkb("mis_no_stall", stall, 1'b0);
        req_q.push_back(mk_req(1'b1, 1'b0, 32'h104, 4'hF, 32'h0));
        load_q.push_back(32'hCAFEF00D);
        issue(32'h104, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0);
        chkb("mis_pulse_once", misaligned, 1'b0);
        chkb("mis_next_read", bus.memory_read, 1'b1);
        bus.memory_req_ready = 1'b1;
        cyc();
        bus.memory_req_ready  = 1'b0;
        bus.memory_resp_valid = 1'b1;
        bus.memory_resp_data  = 32'hCAFEF00D;
        cyc();
        bus.memory_resp_valid = 1'b0;
        chkb("mis_next_valid", load_valid, 1'b1);
        cyc();

        // Illegal size and odd half, back to back.
        mis_q.push_back(32'h33);
        issue(32'h33, 1'b0, 1'b1, 2'd3, 1'b0, 32'h0);
        chkb("mis_size3", misaligned, 1'b1);
        chkb("mis_size3_no_write", bus.memory_write, 1'b0);
        mis_q.push_back(32'h45);
        issue(32'h45, 1'b1, 1'b0, 2'd1, 1'b0, 32'h0);
        chkb("mis_half", misaligned, 1'b1);
        chk("mis_half_addr", fault_address, 32'h45);
        cyc();
        chkb("mis_half_once", misaligned, 1'b0);

        // Reset while waiting for a response; the late response is ignored.
        req_q.push_back(mk_req(1'b1, 1'b0, 32'h300, 4'hF, 32'h0));
        issue(32'h300, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0);
        bus.memory_req_ready = 1'b1;
        cyc();
        bus.memory_req_ready = 1'b0;
        chkb("rw_in_wait", stall, 1'b1);
        reset = 1'b1;
        cyc();
        chkb("rw_issue_ready", issue_ready, 1'b0);
        chkb("rw_stall", stall, 1'b0);
        chkb("rw_read", bus.memory_read, 1'b0);
        chk("rw_addr", bus.memory_address, 32'h0);
        chk("rw_byte_en", {28'b0, bus.memory_byte_en}, 32'h0);
        chk("rw_fault", fault_address, 32'h0);
        reset = 1'b0;
        bus.memory_resp_valid = 1'b1;
        bus.memory_resp_data  = 32'h55555555;
        cyc();
        bus.memory_resp_valid = 1'b0;
        chkb("rw_no_valid", load_valid, 1'b0);
        chk("rw_load_data", load_data, 32'h0);
        chkb("rw_ready", issue_ready, 1'b1);

        // Load followed by a non-memory op held on the issue port.
        req_q.push_back(mk_req(1'b1, 1'b0, 32'h10, 4'hF, 32'h0));
        load_q.push_back(32'h11223344);
        issue(32'h10, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0);
        issue_valid = 1'b1; load = 1'b0; store = 1'b0;
        log2_bytes = 2'd3; ALU_result = 32'h13;
        bus.memory_req_ready = 1'b1;
        chkb("b2b_blocked_req", issue_ready, 1'b0);
        cyc();
        bus.memory_req_ready  = 1'b0;
        bus.memory_resp_valid = 1'b1;
        bus.memory_resp_data  = 32'h11223344;
        chkb("b2b_blocked_wait", issue_ready, 1'b0);
        cyc();
        bus.memory_resp_valid = 1'b0;
        chkb("b2b_load_valid", load_valid, 1'b1);
        chk("b2b_load_data", load_data, 32'h11223344);
        chkb("b2b_accept", issue_ready, 1'b1);
        for (int i = 0; i < 2; i++) begin
            cyc();
            chkb("nop_ready", issue_ready, 1'b1);
            chkb("nop_no_read", bus.memory_read, 1'b0);
            chkb("nop_no_write", bus.memory_write, 1'b0);
            chkb("nop_no_fault", misaligned, 1'b0);
            chkb("nop_no_stall", stall, 1'b0);
        end
        issue_valid = 1'b0;
        cyc(); cyc();

        chk("req_q_drained", 32'(req_q.size()), 32'h0);
        chk("load_q_drained", 32'(load_q.size()), 32'h0);
        chk("mis_q_drained", 32'(mis_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
